// File: rtl/rtc_time_poller.sv
// rtc_time_poller: command stage for I2cMaster that polls a DS1307-style RTC.
// Periodically reads seconds/minutes/hours (registers 0..2) and presents them
// as registered BCD time; performs a four-byte time-set write on request.
// Ports:
//   clock, reset (async, active-low)
//   setTime/newSeconds/newMinutes/newHours : time-set request and values
//   seconds/minutes/hours/timeValid/clockHalted : last successfully read time
//   setDone : one-cycle pulse on write completion
//   errorCount : saturating count of failed transactions
//   i2c* : command/handshake interface to I2cMaster
module rtc_time_poller #(
  parameter int unsigned ClockFrequency     = 24_000_000,
  parameter int unsigned PollPeriodMs       = 100,
  parameter logic [6:0]  RtcAddress         = 7'h68,
  parameter int unsigned ReadyTimeoutCycles = 2_400_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        setTime,
  input  logic [6:0]  newSeconds,
  input  logic [6:0]  newMinutes,
  input  logic [5:0]  newHours,
  output logic [6:0]  seconds,
  output logic [6:0]  minutes,
  output logic [5:0]  hours,
  output logic        timeValid,
  output logic        clockHalted,
  output logic        setDone,
  output logic [7:0]  errorCount,
  output logic        i2cStart,
  output logic [6:0]  i2cAddress,
  output logic [2:0]  i2cNrOfBytesToSend,
  output logic [31:0] i2cBytesToSend,
  output logic [1:0]  i2cNrOfBytesToRead,
  input  logic [23:0] i2cBytesToRead,
  input  logic        i2cReady,
  input  logic        i2cClockStretchTimeoutReached
);

  localparam int unsigned PeriodCycles = ClockFrequency / 1000 * PollPeriodMs;
  localparam int unsigned PeriodW      = $clog2(PeriodCycles + 1);
  localparam int unsigned TimeoutW     = $clog2(ReadyTimeoutCycles + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunchRead,
    StLaunchWrite,
    StWaitBusy,
    StWaitDone,
    StFail
  } state_e;

  state_e              state_q, state_d;
  logic [PeriodW-1:0]  period_q, period_d;
  logic [TimeoutW-1:0] tmo_q, tmo_d;
  logic                poll_due_q, poll_due_d;
  logic                set_pend_q, set_pend_d;
  logic                op_write_q, op_write_d;
  logic [6:0]          new_sec_q, new_sec_d;
  logic [6:0]          new_min_q, new_min_d;
  logic [5:0]          new_hr_q, new_hr_d;
  logic [6:0]          sec_q, sec_d;
  logic [6:0]          min_q, min_d;
  logic [5:0]          hr_q, hr_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                set_done_q, set_done_d;
  logic [7:0]          err_q, err_d;
  logic                start_q, start_d;
  logic [2:0]          nsend_q, nsend_d;
  logic [1:0]          nread_q, nread_d;
  logic [31:0]         bytes_q, bytes_d;

  logic wrap;
  logic tmo_hit;
  logic write_ok;

  // Bits of the read bytes that carry no time information.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{i2cBytesToRead[23:22], i2cBytesToRead[15]};

  assign wrap    = (period_q == PeriodW'(PeriodCycles - 1));
  assign tmo_hit = (tmo_q == TimeoutW'(ReadyTimeoutCycles - 1));

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      period_q   <= '0;
      tmo_q      <= '0;
      poll_due_q <= 1'b0;
      set_pend_q <= 1'b0;
      op_write_q <= 1'b0;
      new_sec_q  <= '0;
      new_min_q  <= '0;
      new_hr_q   <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      set_done_q <= 1'b0;
      err_q      <= '0;
      start_q    <= 1'b0;
      nsend_q    <= '0;
      nread_q    <= '0;
      bytes_q    <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      tmo_q      <= tmo_d;
      poll_due_q <= poll_due_d;
      set_pend_q <= set_pend_d;
      op_write_q <= op_write_d;
      new_sec_q  <= new_sec_d;
      new_min_q  <= new_min_d;
      new_hr_q   <= new_hr_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      set_done_q <= set_done_d;
      err_q      <= err_d;
      start_q    <= start_d;
      nsend_q    <= nsend_d;
      nread_q    <= nread_d;
      bytes_q    <= bytes_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    period_d   = wrap ? '0 : period_q + PeriodW'(1);
    poll_due_d = poll_due_q | wrap;
    set_pend_d = set_pend_q;
    op_write_d = op_write_q;
    new_sec_d  = new_sec_q;
    new_min_d  = new_min_q;
    new_hr_d   = new_hr_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    set_done_d = 1'b0;
    err_d      = err_q;
    start_d    = 1'b0;
    nsend_d    = nsend_q;
    nread_d    = nread_q;
    bytes_d    = bytes_q;
    write_ok   = 1'b0;

    case (state_q)
      StIdle: begin
        if (set_pend_q) begin
          state_d    = StLaunchWrite;
          op_write_d = 1'b1;
        end else if (poll_due_q) begin
          state_d    = StLaunchRead;
          op_write_d = 1'b0;
          // A wrap landing on the launch cycle is a new poll, keep it.
          poll_due_d = wrap;
        end
      end
      StLaunchRead, StLaunchWrite: begin
        if (i2cReady) begin
          start_d = 1'b1;
          state_d = StWaitBusy;
        end else if (tmo_hit) begin
          state_d = StFail;
        end
      end
      StWaitBusy: begin
        if (!i2cReady) begin
          state_d = StWaitDone;
        end else if (tmo_hit) begin
          state_d = StFail;
        end
      end
      StWaitDone: begin
        if (i2cReady) begin
          if (i2cClockStretchTimeoutReached) begin
            state_d = StFail;
          end else if (op_write_q) begin
            set_done_d = 1'b1;
            write_ok   = 1'b1;
            state_d    = StIdle;
          end else begin
            sec_d    = i2cBytesToRead[6:0];
            halted_d = i2cBytesToRead[7];
            min_d    = i2cBytesToRead[14:8];
            hr_d     = i2cBytesToRead[21:16];
            valid_d  = 1'b1;
            state_d  = StIdle;
          end
        end else if (tmo_hit) begin
          state_d = StFail;
        end
      end
      StFail: begin
        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Setup follows the launch state so it is stable on the start strobe.
    if (state_d == StLaunchRead) begin
      nsend_d = 3'd1;
      nread_d = 2'd3;
      bytes_d = 32'h0000_0000;
    end else if (state_d == StLaunchWrite) begin
      nsend_d = 3'd4;
      nread_d = 2'd0;
      bytes_d = {2'b00, new_hr_q, 1'b0, new_min_q, 1'b0, new_sec_q, 8'h00};
    end

    // A fresh request always wins over the clear from a completing write.
    if (setTime) begin
      set_pend_d = 1'b1;
      new_sec_d  = newSeconds;
      new_min_d  = newMinutes;
      new_hr_d   = newHours;
    end else if (write_ok) begin
      set_pend_d = 1'b0;
    end

    tmo_d = (state_d != state_q) ? '0 : tmo_q + TimeoutW'(1);
  end

  assign seconds            = sec_q;
  assign minutes            = min_q;
  assign hours              = hr_q;
  assign timeValid          = valid_q;
  assign clockHalted        = halted_q;
  assign setDone            = set_done_q;
  assign errorCount         = err_q;
  assign i2cStart           = start_q;
  assign i2cAddress         = RtcAddress;
  assign i2cNrOfBytesToSend = nsend_q;
  assign i2cBytesToSend     = bytes_q;
  assign i2cNrOfBytesToRead = nread_q;

endmodule

// File: doc/rtc_time_poller.md
Name: rtc_time_poller

Overview:
- Upstream command stage for I2cMaster in the clock design; sole driver of its start/address/byte inputs.
- Periodically reads seconds/minutes/hours from a DS1307-style RTC at I2C address 0x68 and presents them as registered BCD time for the display logic.
- Also performs a time-set write on request.

Parameters:
- ClockFrequency, 24_000_000, system clock in Hz.
- PollPeriodMs, 100, interval between read transactions in ms; must be >= 1.
- RtcAddress, 7'h68, 7-bit I2C slave address.
- ReadyTimeoutCycles, 2_400_000, maximum clock cycles to wait for i2cReady to return before aborting.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- setTime  in  1  one-cycle request to write newHours/newMinutes/newSeconds.
- newSeconds  in  7  BCD 00-59.
- newMinutes  in  7  BCD 00-59.
- newHours  in  6  BCD 00-23.
- seconds  out  7  BCD seconds, CH bit stripped.
- minutes  out  7  BCD minutes.
- hours  out  6  BCD hours, 24 h mode.
- timeValid  out  1  high after the first successful read.
- clockHalted  out  1  CH bit (seconds register bit 7) from the last successful read.
- setDone  out  1  one-cycle pulse when a write completes without timeout.
- errorCount  out  8  saturating count of failed transactions.
- i2cStart  out  1  start strobe to I2cMaster.
- i2cAddress  out  7  always RtcAddress.
- i2cNrOfBytesToSend  out  3  number of bytes to send.
- i2cBytesToSend  out  32  byte k = bits [8k+7:8k]; byte 0 is sent first.
- i2cNrOfBytesToRead  out  2  number of bytes to read.
- i2cBytesToRead  in  24  byte 0 = first byte received.
- i2cReady  in  1  master idle.
- i2cClockStretchTimeoutReached  in  1  master stretch-timeout flag.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, period counter=0, pending set cleared.
  - All time outputs 0; timeValid, clockHalted, setDone, i2cStart = 0; errorCount = 0.
  - i2cNrOfBytesToSend, i2cNrOfBytesToRead, i2cBytesToSend = 0.
- Period counter:
  - Counts 0 .. ClockFrequency/1000*PollPeriodMs-1, then wraps.
  - The wrap cycle raises an internal pollDue flag, which is cleared when a read is launched.
- Transaction setup:
  - Read: send=1 (byte0=0x00), read=3.
  - Write: send=4 with bytes 0x00, {1'b0,newSeconds}, {1'b0,newMinutes}, {2'b00,newHours}. CH=0 restarts the oscillator.
  - newSeconds/newMinutes/newHours are latched on the setTime cycle; a later setTime overwrites the pending values.
- States:
  - IDLE: if pending set, go to LAUNCH_WRITE; else if pollDue, go to LAUNCH_READ. Write has priority.
  - LAUNCH_x: drive the byte setup; when i2cReady=1, assert i2cStart for exactly one cycle and go to WAIT_BUSY. If i2cReady stays 0 for ReadyTimeoutCycles, go to FAIL.
  - WAIT_BUSY: wait for i2cReady=0, then go to WAIT_DONE; timeout goes to FAIL.
  - WAIT_DONE: wait for i2cReady=1.
    - If i2cClockStretchTimeoutReached=1 at that cycle, go to FAIL.
    - Read success: capture seconds=byte0[6:0], clockHalted=byte0[7], minutes=byte1[6:0], hours=byte2[5:0]; set timeValid=1 the same edge; go to IDLE.
    - Write success: pulse setDone one cycle; clear pending; go to IDLE.
    - Timeout: go to FAIL.
  - FAIL: errorCount+1 (saturates at 255); go to IDLE. Time outputs and timeValid are held. A failed write keeps pending set and retries. A failed read waits for the next pollDue.
- Timeout counter:
  - Reset on every state entry.
  - One shared counter serves LAUNCH_x, WAIT_BUSY and WAIT_DONE.
- Simultaneous events:
  - setTime arriving during a read is latched and served right after that read.
  - pollDue arriving during a transaction is held and served afterward; at most one pending poll is kept, so extra wraps are dropped.
- Output timing: outputs update one clock after the qualifying input (registered).
- Reset mid-transaction: immediate return to reset values, no completion pulse, pending set lost.

Test Plan:
- Set PollPeriodMs=1 and a slave returning 0x45,0x30,0x12 -> after the first transaction: seconds=7'h45, minutes=7'h30, hours=6'h12, timeValid=1, clockHalted=0, errorCount=0; i2cStart pulses exactly once per 24_000 cycles.
- Slave seconds byte 0x80 -> seconds=0, clockHalted=1.
- setTime with 7'h59/7'h59/6'h23 while a read is in WAIT_DONE -> the read completes first, then a write with i2cNrOfBytesToSend=4 and i2cBytesToSend=32'h23_59_59_00; setDone pulses once.
- Force i2cClockStretchTimeoutReached=1 at completion of a read -> errorCount=1, previous time held, next poll retries normally.
- Hold i2cReady=0 with ReadyTimeoutCycles=100 -> FAIL after 100 cycles, i2cStart never asserted, errorCount increments once per attempt.
- Assert reset=0 during WAIT_DONE -> all outputs 0 asynchronously, i2cStart=0; after release the first read starts at the next counter wrap.
